// File: rtl/morse_receiver.sv
// Morse receiver: synchronises the light line, measures mark and space runs
// in clock cycles and decodes letters J..Q back to their 3-bit code.
//
// state | meaning
// IDLE  | no letter in progress, waiting for a mark
// MARK  | line high, counting the mark length
// SPACE | line low inside a letter, counting the gap length
// EMIT  | gap long enough, decode the pattern and strobe
module morse_receiver #(
  parameter int MIN_PULSE = 2,
  parameter int DASH_MIN  = 8,
  parameter int GAP_END   = 16,
  parameter int CNT_W     = 8
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic [2:0] sym_count
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] DASH_M  = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] GAP_E   = CNT_W'(GAP_END);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             rst;
  logic             sync1, s_in;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d, gap_q, gap_d;
  logic [3:0]       pat_q, pat_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       letter_d;
  logic             valid_d, err_d;
  logic [3:0]       dec;

  assign rst       = KEY;
  assign sym_count = cnt_q;

  // Returns {hit, code}; pattern bit i is symbol i (1 = dash), unused bits are 0.
  function automatic logic [3:0] decode(input logic [2:0] n, input logic [3:0] p);
    case ({n, p})
      7'b100_1110: decode = 4'b1_000;
      7'b011_0101: decode = 4'b1_001;
      7'b100_0010: decode = 4'b1_010;
      7'b010_0011: decode = 4'b1_011;
      7'b010_0001: decode = 4'b1_100;
      7'b011_0111: decode = 4'b1_101;
      7'b100_0110: decode = 4'b1_110;
      7'b100_1011: decode = 4'b1_111;
      default:     decode = 4'b0_000;
    endcase
  endfunction

  assign dec = decode(cnt_q, pat_q);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s_in  <= 1'b0;
    end else begin
      sync1 <= morse_in;
      s_in  <= sync1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      run_q        <= '0;
      gap_q        <= '0;
      pat_q        <= '0;
      cnt_q        <= '0;
      letter       <= '0;
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      gap_q        <= gap_d;
      pat_q        <= pat_d;
      cnt_q        <= cnt_d;
      letter       <= letter_d;
      letter_valid <= valid_d;
      letter_err   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    gap_d    = gap_q;
    pat_d    = pat_q;
    cnt_d    = cnt_q;
    letter_d = letter;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_in) begin
          state_d = MARK;
          run_d   = ONE;
        end
      end
      MARK: begin
        if (s_in) begin
          if (run_q != CNT_MAX) run_d = run_q + ONE;
        end else if (run_q < MIN_P) begin
          // Glitch: the low cycle that ends it restarts the gap count.
          state_d = (cnt_q != 3'd0) ? SPACE : IDLE;
          gap_d   = ONE;
        end else begin
          if (cnt_q < 3'd4) pat_d[cnt_q[1:0]] = (run_q >= DASH_M);
          if (cnt_q != 3'd5) cnt_d = cnt_q + 3'd1;
          state_d = SPACE;
          gap_d   = ONE;
        end
      end
      SPACE: begin
        if (s_in) begin
          state_d = MARK;
          run_d   = ONE;
        end else begin
          gap_d = gap_q + ONE;
          if (gap_d == GAP_E) state_d = EMIT;
        end
      end
      EMIT: begin
        if (cnt_q != 3'd5 && dec[3]) begin
          valid_d  = 1'b1;
          letter_d = dec[2:0];
        end else begin
          err_d = 1'b1;
        end
        pat_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_morse_receiver.sv
// Bench for morse_receiver: run-length reference model over the sampled line,
// per-cycle output comparison, directed letters plus random waveforms.
module tb_morse_receiver;
  localparam int MAXN      = 4096;
  localparam int MIN_PULSE = 2;
  localparam int DASH_MIN  = 8;
  localparam int GAP_END   = 16;

  logic       CLOCK_50 = 1'b0;
  logic       KEY = 1'b1;
  logic       morse_in = 1'b0;
  logic [2:0] letter, sym_count;
  logic       letter_valid, letter_err;

  morse_receiver dut (
    .CLOCK_50(CLOCK_50), .KEY(KEY), .morse_in(morse_in),
    .letter(letter), .letter_valid(letter_valid),
    .letter_err(letter_err), .sym_count(sym_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  bit         pin_q[$];
  int         n;
  int         fin[MAXN];
  int         ev_sc[MAXN];
  int         ev_emit[MAXN];
  int         ev_code[MAXN];
  bit         exp_v[MAXN];
  bit         exp_e[MAXN];
  logic [2:0] exp_l[MAXN];
  logic [2:0] exp_sc[MAXN];

  int         checks = 0;
  int         failures = 0;
  bit         chk_on = 1'b0;
  int         cur_e = 0;
  int         first_v, err_cnt, peak_sc;
  int         valid_log[$];
  string      codes[8] = '{".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-"};

  task automatic chk(string name, int e, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, e, got, want);
    end
  endtask

  task automatic add(bit lvl, int len);
    repeat (len) pin_q.push_back(lvl);
  endtask

  task automatic mk(int mark, int gap);
    add(1'b1, mark);
    add(1'b0, gap);
  endtask

  function automatic int log_at(int i);
    return (valid_log.size() > i) ? valid_log[i] : -1;
  endfunction

  // Reference: split the line as seen two edges late into runs; each finished
  // mark is a glitch, dot or dash; a gap of GAP_END lows inside a letter emits
  // on the following edge, and that edge's sample is lost to the next mark.
  task automatic build_model();
    int    sym, e, s, len, lvl, trim_at, x, code, cur_sc, cur_l;
    string pat;
    n = pin_q.size();
    for (int i = 0; i < n; i++) begin
      fin[i]     = (i >= 2) ? int'(pin_q[i-2]) : 0;
      ev_sc[i]   = -1;
      ev_emit[i] = 0;
      ev_code[i] = 0;
    end
    sym = 0; pat = ""; trim_at = -1; e = 0;
    while (e < n) begin
      s = e; lvl = fin[e];
      while (e < n && fin[e] == lvl) e++;
      len = e - s;
      if (lvl == 1) begin
        if (s == trim_at) begin s++; len--; end
        if (len > 0 && e < n && len >= MIN_PULSE) begin
          if (sym < 4) begin
            if (len >= DASH_MIN) pat = {pat, "-"};
            else pat = {pat, "."};
          end
          if (sym < 5) sym++;
          ev_sc[e] = sym;
        end
      end else if (sym > 0 && len >= GAP_END && s + GAP_END < n) begin
        x = s + GAP_END;
        code = -1;
        if (sym < 5)
          for (int i = 0; i < 8; i++) if (pat == codes[i]) code = i;
        ev_sc[x]   = 0;
        ev_emit[x] = (code >= 0) ? 1 : 2;
        ev_code[x] = (code >= 0) ? code : 0;
        trim_at = x;
        sym = 0; pat = "";
      end
    end
    cur_sc = 0; cur_l = 0;
    for (int i = 0; i < n; i++) begin
      if (ev_sc[i] >= 0) cur_sc = ev_sc[i];
      if (ev_emit[i] == 1) cur_l = ev_code[i];
      exp_v[i]  = (ev_emit[i] == 1);
      exp_e[i]  = (ev_emit[i] == 2);
      exp_l[i]  = 3'(cur_l);
      exp_sc[i] = 3'(cur_sc);
    end
  endtask

  task automatic run_phase();
    build_model();
    KEY = 1'b1;
    morse_in = 1'b0;
    #1;
    chk("rst_letter", -1, letter, 0);
    chk("rst_valid", -1, letter_valid, 0);
    chk("rst_err", -1, letter_err, 0);
    chk("rst_symcnt", -1, sym_count, 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    KEY = 1'b0;
    first_v = -1; err_cnt = 0; peak_sc = 0;
    valid_log.delete();
    for (int e = 0; e < n; e++) begin
      morse_in = pin_q[e];
      cur_e = e;
      chk_on = 1'b1;
      @(negedge CLOCK_50);
    end
    chk_on = 1'b0;
  endtask

  always @(posedge CLOCK_50) begin
    #2;
    if (chk_on) begin
      chk("letter_valid", cur_e, letter_valid, exp_v[cur_e]);
      chk("letter_err", cur_e, letter_err, exp_e[cur_e]);
      chk("letter", cur_e, letter, exp_l[cur_e]);
      chk("sym_count", cur_e, sym_count, exp_sc[cur_e]);
      if (letter_valid === 1'b1) begin
        valid_log.push_back(int'(letter));
        if (first_v < 0) first_v = cur_e;
      end
      if (letter_err === 1'b1) err_cnt++;
      if (int'(sym_count) > peak_sc) peak_sc = int'(sym_count);
    end
  end

  function automatic int rand_hi();
    int r;
    r = $urandom_range(0, 19);
    if (r <= 1) return 1;
    if (r == 2) return 2;
    if (r <= 7) return $urandom_range(2, 7);
    if (r == 8) return 7;
    if (r == 9) return 8;
    if (r <= 16) return $urandom_range(8, 14);
    if (r == 17) return $urandom_range(255, 300);
    return 3;
  endfunction

  function automatic int rand_lo();
    int r;
    r = $urandom_range(0, 15);
    if (r <= 5) return $urandom_range(1, 14);
    if (r <= 7) return 15;
    if (r <= 9) return 16;
    if (r == 10) return 17;
    if (r <= 13) return $urandom_range(18, 30);
    return 5;
  endfunction

  initial begin
    // J: .---
    pin_q.delete(); add(0, 3);
    mk(5, 5); mk(11, 5); mk(11, 5); mk(11, 20);
    run_phase();
    chk("model_j_edge", 74, exp_v[74], 1);
    chk("j_first_valid_edge", -1, first_v, 74);
    chk("j_valid_count", -1, valid_log.size(), 1);
    chk("j_letter", -1, log_at(0), 0);
    chk("j_err_count", -1, err_cnt, 0);
    chk("j_symcnt_end", -1, sym_count, 0);

    // N then Q back to back
    pin_q.delete(); add(0, 3);
    mk(11, 5); mk(5, 20);
    mk(11, 5); mk(11, 5); mk(5, 5); mk(11, 20);
    run_phase();
    chk("nq_valid_count", -1, valid_log.size(), 2);
    chk("nq_first", -1, log_at(0), 4);
    chk("nq_second", -1, log_at(1), 7);
    chk("nq_err_count", -1, err_cnt, 0);

    // L with 7/8 thresholds and 15-cycle gaps
    pin_q.delete(); add(0, 3);
    mk(7, 15); mk(8, 15); mk(7, 15); mk(7, 20);
    run_phase();
    chk("l_valid_count", -1, valid_log.size(), 1);
    chk("l_letter", -1, log_at(0), 2);
    chk("l_err_count", -1, err_cnt, 0);

    // same marks, 16-cycle gap after the second splits into two bad letters
    pin_q.delete(); add(0, 3);
    mk(7, 15); mk(8, 16); mk(7, 15); mk(7, 20);
    run_phase();
    chk("lsplit_valid_count", -1, valid_log.size(), 0);
    chk("lsplit_err_count", -1, err_cnt, 2);

    // M with a one-cycle glitch inside the gap
    pin_q.delete(); add(0, 3);
    mk(11, 5); mk(1, 5); mk(11, 20);
    run_phase();
    chk("glitch_valid_count", -1, valid_log.size(), 1);
    chk("glitch_letter", -1, log_at(0), 3);
    chk("glitch_sym_peak", -1, peak_sc, 2);

    // O, then unrecognised "...", then five-symbol overflow
    pin_q.delete(); add(0, 3);
    mk(11, 5); mk(11, 5); mk(11, 20);
    mk(5, 5); mk(5, 5); mk(5, 20);
    mk(5, 5); mk(5, 5); mk(5, 5); mk(5, 5); mk(5, 20);
    run_phase();
    chk("ovf_valid_count", -1, valid_log.size(), 1);
    chk("ovf_err_count", -1, err_cnt, 2);
    chk("ovf_letter_held", -1, letter, 5);
    chk("ovf_sym_peak", -1, peak_sc, 5);

    // O, then two marks of K, then asynchronous reset mid-letter
    pin_q.delete(); add(0, 3);
    mk(11, 5); mk(11, 5); mk(11, 20);
    mk(11, 5); mk(5, 5);
    run_phase();
    chk("midrst_pre_symcnt", -1, sym_count, 2);
    chk("midrst_pre_letter", -1, letter, 5);
    #3;
    KEY = 1'b1;
    #1;
    chk("midrst_letter", -1, letter, 0);
    chk("midrst_valid", -1, letter_valid, 0);
    chk("midrst_err", -1, letter_err, 0);
    chk("midrst_symcnt", -1, sym_count, 0);

    // full M after the reset
    pin_q.delete(); add(0, 3);
    mk(11, 5); mk(11, 20);
    run_phase();
    chk("m_valid_count", -1, valid_log.size(), 1);
    chk("m_letter", -1, log_at(0), 3);

    for (int p = 0; p < 8; p++) begin
      pin_q.delete(); add(0, 3);
      while (pin_q.size() < 1400) mk(rand_hi(), rand_lo());
      add(0, 20);
      run_phase();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
